// File: rtl/sr_pkg.sv
// Shared definitions for blocks that talk to an SR flip-flop: state encoding,
// default timing parameters and the counter-width helper.
package sr_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DRIVE     = 2'd1;
  localparam logic [1:0] WAIT_ECHO = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

  localparam int SR_HOLD_CYCLES_DEFAULT  = 4;
  localparam int SR_ECHO_TIMEOUT_DEFAULT = 3;

  // One spare bit above what the larger count needs.
  function automatic int sr_cnt_width(input int hold_cycles, input int echo_timeout);
    int m;
    m = (hold_cycles > echo_timeout) ? hold_cycles : echo_timeout;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Request handshake plus the SR flip-flop pins. master = requester/flip-flop
// environment, slave = the sr_ff_driver block.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is decoded from state only; req_valid is not queued while busy.
interface sr_ff_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic s;
  logic r;
  logic q_fb;
  logic done;
  logic err;
  logic busy;

  modport master (
    output req_valid, req_level, q_fb,
    input  req_ready, s, r, done, err, busy
  );

  modport slave (
    input  req_valid, req_level, q_fb,
    output req_ready, s, r, done, err, busy
  );
endinterface

// File: rtl/sr_cycle_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module sr_cycle_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_ff_driver.sv
// Drives one mutually exclusive s/r pulse per accepted level change, checks the
// flip-flop echo and holds the new level for HOLD_CYCLES before the next request.
module sr_ff_driver
  import sr_pkg::*;
#(
  parameter int HOLD_CYCLES  = SR_HOLD_CYCLES_DEFAULT,
  parameter int ECHO_TIMEOUT = SR_ECHO_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  sr_ff_driver_if.slave       bus,
  output logic [1:0]          state_dbg
);

  localparam int CW = sr_cnt_width(HOLD_CYCLES, ECHO_TIMEOUT);
  // Loaded with N-1 so the zero flag marks the last cycle of an N-cycle window.
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ECHO_LOAD = CW'(ECHO_TIMEOUT - 1);

  logic [1:0]    state;
  logic          target;
  logic          accept;
  logic          echo_match;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;
  logic          cnt_zero;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE) && !rst;
  assign state_dbg     = state;

  assign accept     = bus.req_valid && bus.req_ready;
  assign echo_match = (bus.q_fb == target);

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = ECHO_LOAD;
    cnt_dec      = 1'b0;
    case (state)
      DRIVE: begin
        cnt_load     = 1'b1;
        cnt_load_val = ECHO_LOAD;
      end
      WAIT_ECHO: begin
        if (echo_match) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD:    cnt_dec = 1'b1;
      default: ;
    endcase
  end

  sr_cycle_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target   <= 1'b0;
      bus.s    <= 1'b0;
      bus.r    <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      bus.s    <= 1'b0;
      bus.r    <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target <= bus.req_level;
            // Flip-flop already at the requested level: confirm without pulsing.
            if (bus.req_level == bus.q_fb) begin
              bus.done <= 1'b1;
            end else begin
              state <= DRIVE;
              bus.s <= bus.req_level;
              bus.r <= ~bus.req_level;
            end
          end
        end
        DRIVE: state <= WAIT_ECHO;
        WAIT_ECHO: begin
          if (echo_match) begin
            state    <= HOLD;
            bus.done <= 1'b1;
          end else if (cnt_zero) begin
            state   <= IDLE;
            bus.err <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_zero) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Randomised scoreboard bench for sr_ff_driver against a transaction-level model
// and a behavioural posedge SR flip-flop (optionally stuck to force timeouts).
module tb_sr_ff_driver;
  import sr_pkg::*;

  localparam int H = 4;
  localparam int T = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_ff_driver_if bus ();
  logic [1:0] state_dbg;

  sr_ff_driver #(.HOLD_CYCLES(H), .ECHO_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // downstream flip-flop, with an override to model a broken echo path
  logic ff_q = 1'b0;
  logic stuck_en = 1'b0;
  logic stuck_val = 1'b0;
  assign bus.q_fb = stuck_en ? stuck_val : ff_q;

  always @(posedge clk) begin
    if (bus.s === 1'b1) ff_q <= 1'b1;
    else if (bus.r === 1'b1) ff_q <= 1'b0;
  end

  // scoreboard: events are {cycle, s, r, done, err}
  logic [31:0] exp_q[$];
  int edge_n  = 0;
  int free_at = 0;
  int checks  = 0;
  int errors  = 0;

  function automatic logic [31:0] ev(input int cyc, input logic s, input logic r,
                                     input logic d, input logic e);
    logic [27:0] c;
    c = cyc[27:0];
    return {c, s, r, d, e};
  endfunction

  task automatic check1(input string name, input int cyc, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Reference model: cycle k is the interval ending at rising edge k.
  // A request sampled at edge A is decided from the rules of the interface.
  always @(posedge clk) begin : model
    int e;
    logic [31:0] keep[$];
    e = edge_n + 1;
    edge_n = e;
    if (rst) begin
      keep = {};
      foreach (exp_q[i]) if (int'(exp_q[i][31:4]) <= e) keep.push_back(exp_q[i]);
      exp_q = keep;
      free_at = e + 1;
    end else if (bus.req_valid && e >= free_at) begin
      if (bus.req_level == bus.q_fb) begin
        exp_q.push_back(ev(e + 1, 1'b0, 1'b0, 1'b1, 1'b0));
      end else begin
        exp_q.push_back(ev(e + 1, bus.req_level, !bus.req_level, 1'b0, 1'b0));
        if (stuck_en) begin
          exp_q.push_back(ev(e + 2 + T, 1'b0, 1'b0, 1'b0, 1'b1));
          free_at = e + 2 + T;
        end else begin
          exp_q.push_back(ev(e + 3, 1'b0, 1'b0, 1'b1, 1'b0));
          free_at = e + 3 + H;
        end
      end
    end
  end

  // monitor on the falling edge
  always @(negedge clk) begin : monitor
    int x;
    logic exp_ready;
    logic have_out;
    logic front_now;
    logic [31:0] got;
    logic [31:0] want;
    if (edge_n >= 1) begin
      x = edge_n + 1;
      exp_ready = !rst && (x >= free_at);
      check1("req_ready", x, bus.req_ready, exp_ready);
      check1("busy", x, bus.busy, !rst && !exp_ready);
      if (exp_ready) check1("state_idle", x, (state_dbg == IDLE), 1'b1);
      check1("s_and_r", x, bus.s && bus.r, 1'b0);
      check1("done_and_err", x, bus.done && bus.err, 1'b0);
      while (exp_q.size() > 0 && int'(exp_q[0][31:4]) < x) begin
        checks++;
        errors++;
        $display("FAIL missed_event cycle %0d expected %h", x, exp_q[0]);
        void'(exp_q.pop_front());
      end
      have_out  = (bus.s === 1'b1) || (bus.r === 1'b1) || (bus.done === 1'b1) || (bus.err === 1'b1);
      front_now = (exp_q.size() > 0) && (int'(exp_q[0][31:4]) == x);
      if (have_out || front_now) begin
        checks++;
        got = ev(x, bus.s, bus.r, bus.done, bus.err);
        if (!front_now) begin
          errors++;
          $display("FAIL unexpected_event cycle %0d got s=%b r=%b done=%b err=%b",
                   x, bus.s, bus.r, bus.done, bus.err);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event cycle %0d got s/r/done/err=%b expected %b",
                     x, got[3:0], want[3:0]);
          end
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input logic v, input logic lvl);
    bus.req_valid = v;
    bus.req_level = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_level = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset then set: flip-flop starts at 0
    step(1'b1, 1'b1);
    idle(10);

    // back-to-back with req_valid held high
    for (int i = 0; i < H + 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < H + 3; i++) step(1'b1, 1'b1);
    idle(10);

    // no-op: flip-flop already at 1
    step(1'b1, 1'b1);
    idle(4);

    // ignored traffic during HOLD
    step(1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(10);

    // echo timeout
    stuck_en = 1'b1;
    stuck_val = 1'b0;
    step(1'b1, 1'b1);
    idle(10);
    stuck_en = 1'b0;
    idle(2);

    // reset during DRIVE
    step(1'b1, !bus.q_fb);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    idle(10);

    // randomised traffic with occasional stuck echo and resets
    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(0, 9))
        0: begin
          idle(12);
          stuck_en  = 1'($urandom_range(0, 1));
          stuck_val = 1'($urandom_range(0, 1));
        end
        1: begin
          rst = 1'b1;
          step(1'b0, 1'b0);
          rst = 1'b0;
        end
        default: begin
          for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      endcase
    end

    stuck_en = 1'b0;
    idle(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending events expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
